hawk_axi_mem_slv: RTL

AXI4 responder (slave end) for cacheline-granular HAWK traffic. It answers the read and write requests that the HAWK AXI read/write masters and the crossbar issue toward memory, backed by a local 1W1R RAM of 512-bit lines. It serves as an on-chip table store and as a synthesizable memory-controller stand-in for HACD bring-up.

---
 rtl/hawk_axi_mem_slv_if.sv | 62 ++++++
 rtl/hawk_axi_mem_slv.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hawk_axi_mem_slv_if.sv
// AXI4 bus bundle for the HAWK memory responder: AW/W/B/AR/R channels.
interface hawk_axi_mem_slv_if #(
   parameter int ID_W   = 6,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/hawk_axi_mem_slv.sv
// AXI4 memory responder backed by a 1W1R RAM of cacheline-wide words.
// Independent read and write FSMs; one beat per line, INCR/FIXED only.
// Optional macro HAWK_MEM_SLV_LAT_INJ_EN stretches each read fetch by
// RD_LAT_EXTRA cycles to exercise upstream backpressure.
module hawk_axi_mem_slv #(
   parameter int               ID_W         = 6,
   parameter int               ADDR_W       = 64,
   parameter int               DATA_W       = 512,
   parameter int               DEPTH        = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int               RD_LAT_EXTRA = 0
) (
   input logic               clk,
   input logic               rst,
   hawk_axi_mem_slv_if.slave s_axi
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_W / 8;

   localparam logic [1:0] R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2;
   localparam logic [1:0] W_IDLE = 2'd0, W_DATA  = 2'd1, W_RESP = 2'd2;

   logic [DATA_W-1:0] r_mem [DEPTH];

   function automatic logic f_in_rng(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && ((off >> 6) < ADDR_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return off[6 +: IDX_W];
   endfunction

   // ---------------- write channel ----------------
   logic [1:0]        r_wstate;
   logic [ID_W-1:0]   r_wid;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wlen, r_wcnt;
   logic [1:0]        r_wburst, r_bresp;
   logic              r_wsup, r_wslv, r_wdec;
   logic              w_wrng, w_wend, w_we;
   logic [IDX_W-1:0]  w_widx;

   assign w_wrng = f_in_rng(r_waddr);
   assign w_widx = f_idx(r_waddr);
   assign w_wend = (r_wcnt == r_wlen);
   // Out-of-range or unsupported beats are accepted but dropped.
   assign w_we   = (r_wstate == W_DATA) && s_axi.wvalid && w_wrng && r_wsup;

   // Write FSM: latch AW, take exactly len+1 beats, fold errors into bresp.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wstate <= W_IDLE;
         r_wid    <= '0;
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wcnt   <= '0;
         r_wburst <= '0;
         r_wsup   <= 1'b0;
         r_wslv   <= 1'b0;
         r_wdec   <= 1'b0;
         r_bresp  <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: if (s_axi.awvalid) begin
               r_wid    <= s_axi.awid;
               r_waddr  <= s_axi.awaddr;
               r_wlen   <= s_axi.awlen;
               r_wburst <= s_axi.awburst;
               r_wsup   <= !s_axi.awburst[1] && (s_axi.awsize == 3'd6);
               r_wcnt   <= '0;
               r_wslv   <= 1'b0;
               r_wdec   <= 1'b0;
               r_wstate <= W_DATA;
            end
            W_DATA: if (s_axi.wvalid) begin
               if (w_wend) begin
                  // wlast must be high exactly on the final beat
                  if (!r_wsup || r_wslv || !s_axi.wlast) r_bresp <= 2'b10;
                  else if (r_wdec || !w_wrng)            r_bresp <= 2'b11;
                  else                                   r_bresp <= 2'b00;
                  r_wstate <= W_RESP;
               end else begin
                  r_wslv <= r_wslv | s_axi.wlast;
                  r_wdec <= r_wdec | !w_wrng;
                  r_wcnt <= r_wcnt + 8'd1;
                  if (r_wburst == 2'b01) r_waddr <= r_waddr + ADDR_W'(64);
               end
            end
            W_RESP: if (s_axi.bready) r_wstate <= W_IDLE;
            default: r_wstate <= W_IDLE;
         endcase
      end
   end

   // RAM write port with per-byte strobes; contents are never reset.
   always_ff @(posedge clk) begin
      if (w_we)
         for (int b = 0; b < NB; b++)
            if (s_axi.wstrb[b]) r_mem[w_widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
   end

   assign s_axi.awready = (r_wstate == W_IDLE);
   assign s_axi.wready  = (r_wstate == W_DATA);
   assign s_axi.bvalid  = (r_wstate == W_RESP);
   assign s_axi.bid     = r_wid;
   assign s_axi.bresp   = r_bresp;

   // ---------------- read channel ----------------
   logic [1:0]        r_rstate;
   logic [ID_W-1:0]   r_rid;
   logic [ADDR_W-1:0] r_raddr;
   logic [7:0]        r_rlen, r_rcnt;
   logic [1:0]        r_rburst, r_rresp;
   logic              r_rsup, r_rlast;
   logic [DATA_W-1:0] r_rdata, w_rfwd;
   logic              w_rrng, w_rgo;
   logic [IDX_W-1:0]  w_ridx;

   assign w_rrng = f_in_rng(r_raddr);
   assign w_ridx = f_idx(r_raddr);

`ifdef HAWK_MEM_SLV_LAT_INJ_EN
   logic [15:0] r_rwait;
   assign w_rgo = (r_rstate == R_FETCH) && (r_rwait == 16'(RD_LAT_EXTRA));
`else
   assign w_rgo = (r_rstate == R_FETCH);
`endif

   // Read-during-write to the same line returns the merged new bytes.
   always_comb begin
      w_rfwd = r_mem[w_ridx];
      if (w_we && (w_widx == w_ridx))
         for (int b = 0; b < NB; b++)
            if (s_axi.wstrb[b]) w_rfwd[b*8 +: 8] = s_axi.wdata[b*8 +: 8];
   end

   // Read FSM: one fetch cycle (plus optional wait) then hold the beat until rready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_rid    <= '0;
         r_raddr  <= '0;
         r_rlen   <= '0;
         r_rcnt   <= '0;
         r_rburst <= '0;
         r_rsup   <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= '0;
         r_rlast  <= 1'b0;
`ifdef HAWK_MEM_SLV_LAT_INJ_EN
         r_rwait  <= '0;
`endif
      end else begin
         case (r_rstate)
            R_IDLE: if (s_axi.arvalid) begin
               r_rid    <= s_axi.arid;
               r_raddr  <= s_axi.araddr;
               r_rlen   <= s_axi.arlen;
               r_rburst <= s_axi.arburst;
               r_rsup   <= !s_axi.arburst[1] && (s_axi.arsize == 3'd6);
               r_rcnt   <= '0;
`ifdef HAWK_MEM_SLV_LAT_INJ_EN
               r_rwait  <= '0;
`endif
               r_rstate <= R_FETCH;
            end
            R_FETCH: begin
`ifdef HAWK_MEM_SLV_LAT_INJ_EN
               if (!w_rgo) r_rwait <= r_rwait + 16'd1;
`endif
               if (w_rgo) begin
                  r_rlast <= (r_rcnt == r_rlen);
                  if (!r_rsup) begin
                     r_rdata <= '0;
                     r_rresp <= 2'b10;
                  end else if (!w_rrng) begin
                     r_rdata <= '0;
                     r_rresp <= 2'b11;
                  end else begin
                     r_rdata <= w_rfwd;
                     r_rresp <= 2'b00;
                  end
                  r_rstate <= R_DATA;
               end
            end
            R_DATA: if (s_axi.rready) begin
               if (r_rlast) begin
                  r_rlast  <= 1'b0;
                  r_rstate <= R_IDLE;
               end else begin
                  r_rcnt <= r_rcnt + 8'd1;
                  if (r_rburst == 2'b01) r_raddr <= r_raddr + ADDR_W'(64);
`ifdef HAWK_MEM_SLV_LAT_INJ_EN
                  r_rwait <= '0;
`endif
                  r_rstate <= R_FETCH;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

   assign s_axi.arready = (r_rstate == R_IDLE);
   assign s_axi.rvalid  = (r_rstate == R_DATA);
   assign s_axi.rid     = r_rid;
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;
   assign s_axi.rlast   = r_rlast;
endmodule
